data_cache_param: RTL and testbench
===================================

# data_cache_param

Parametrised direct-mapped, write-through data cache that replaces the fixed data memory between the RV32I core's load/store stage and a word-wide backing memory. It keeps the core-side port (`addr`, `write_data`, `memwrite`, `memread`, `sign_mask`, `read_data`, `clk_stall`) and adds configurable geometry, multi-word line refill over a req/ack bus, misalignment detection and hit/miss counters.

## Interface
- `ADDR_W`, 32, byte-address width.
- `LINES`, 16, number of cache lines; power of two, ≥2.
- `WORDS_PER_LINE`, 4, 32-bit words per line; power of two, ≥1.
- `CNT_W`, 16, width of hit/miss counters.
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `addr`  in  ADDR_W  core byte address.
- `write_data`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `memwrite`  in  1  store request.
- `memread`  in  1  load request.
- `sign_mask`  in  4  [2:0] size: 001 byte, 011 half, 111 word; [3] signed load.
- `read_data`  out  32  load result, aligned and extended.
- `clk_stall`  out  1  core must hold its request and stall.
- `misaligned`  out  1  one-cycle pulse: access rejected.
- `hit_count`, `miss_count`  out  CNT_W  saturating read hit/miss counters.
- `mem_req`  out  1  backing request valid.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  ADDR_W  word-aligned byte address ([1:0]=0).
- `mem_wdata`  out  32  lane-positioned write data.
- `mem_be`  out  4  byte enables (writes only; 0 for reads).
- `mem_rdata`  in  32  read word, valid with `mem_ack`.
- `mem_ack`  in  1  completes the current beat.

## Operation
- Address split: offset [1:0], word [log2(WPL)+1:2], index next log2(LINES) bits, tag the rest.
- States: IDLE, REFILL, WRITE, DONE.
- IDLE, request sampled at edge: memwrite has priority over memread if both high.
- Misaligned (half with addr[0]=1, word with addr[1:0]≠0, or size code not 001/011/111): no memory access, no counter change, `misaligned` high next cycle, stay IDLE.
- Read hit (valid & tag match): lane extracted, zero/sign-extended per sign_mask[3], registered to `read_data`; `hit_count`++; stay IDLE.
- Read miss: `miss_count`++; → REFILL; beats fetch words 0..WPL-1 of the line in order; each ack writes the word; after the final ack set tag/valid, load `read_data` from the requested word → DONE.
- Write (hit or miss): → WRITE; one beat, `mem_we`=1, data replicated into lane, `mem_be` = 0001/0011/1111 shifted by addr[1:0]; on ack, if hit, update the enabled bytes of the cached word; no allocate on miss → DONE.
- DONE: one cycle, inputs ignored, → IDLE.
- `clk_stall` (combinational) = REFILL | WRITE | (IDLE & valid aligned request & (memwrite | read miss)). Low in DONE.
- Counters saturate at all-ones.

## Timing
- Reset: state IDLE, all valid bits 0, `read_data`=0, `misaligned`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0, counters 0; `clk_stall`=0 with no request.
- Read hit: request at edge N, `read_data` valid from N+1, held until next load completes; zero stall.
- `mem_req` rises the cycle after entry to REFILL/WRITE; address/data stable while `mem_req`=1 and `mem_ack`=0; beat completes at edge with both high; during refill `mem_req` stays high and `mem_addr` advances one word per ack.
- Read miss with ack latency L per beat: stall from request cycle through final-ack cycle; DONE cycle has `read_data` valid and stall low.
- `mem_ack` while `mem_req`=0 is ignored.
- Reset asserted mid-REFILL/WRITE: immediate return to reset values; partially filled line stays invalid.

## Test plan
- Byte store 0xAAA at 0x400 (sign_mask 0001), then load signed (1001) -> `read_data`=0xFFFFFFAA; unsigned (0001) -> 0x000000AA; `mem_be`=0001 on store.
- Half store 0x2AAAA at 0x100 (0011), loads 1011 -> 0xFFFFAAAA, 0011 -> 0x0000AAAA.
- Word store 0xAAAAAAAA at 0x40, load 0111 -> 0xAAAAAAAA; first load miss_count=1 with WPL beats at 0x40..0x4C, second load hit_count=1, no stall.
- Two addresses with same index, different tag, alternating loads -> every load misses; miss_count increments each time.
- Half load at 0x101 -> `misaligned` pulse, `mem_req` never asserts, counters unchanged.
- Assert `rst_n`=0 during beat 2 of a refill -> `mem_req`=0 immediately; subsequent load to the same address misses again.

Source files
------------

// File: rtl/data_cache_param.sv
// Direct-mapped write-through data cache with
// multi-word line refill over a req/ack memory bus.
module data_cache_param #(
    parameter int ADDR_W         = 32,
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       write_data,
    input  logic              memwrite,
    input  logic              memread,
    input  logic [3:0]        sign_mask,
    output logic [31:0]       read_data,
    output logic              clk_stall,
    output logic              misaligned,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int WB = $clog2(WORDS_PER_LINE);
    localparam int WI = (WB > 0) ? WB : 1;
    localparam int IB = $clog2(LINES);
    localparam int TB = ADDR_W - 2 - WB - IB;
    localparam logic [WI-1:0] LAST = WI'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;

    state_t state_q, state_d;

    logic [31:0]       dmem [LINES][WORDS_PER_LINE];
    logic [TB-1:0]     tags [LINES];
    logic [LINES-1:0]  valid;

    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_sm;
    logic              r_hit;
    logic [WI-1:0]     beat;

    logic [IB-1:0]     idx, r_idx;
    logic [TB-1:0]     tag, r_tag;
    logic [WI-1:0]     wsel, r_wsel;
    logic [2:0]        sz;
    logic              align_ok, req_any, req_ok, bad_req, hit;
    logic              last_beat, ack_ok;
    logic [31:0]       rep_data, fill_word;
    logic [3:0]        be_base;
    logic [ADDR_W-1:0] word_addr, line_addr;

    assign idx   = addr[2+WB +: IB];
    assign tag   = addr[ADDR_W-1 -: TB];
    assign r_idx = r_addr[2+WB +: IB];
    assign r_tag = r_addr[ADDR_W-1 -: TB];

    if (WB > 0) begin : g_wsel
        assign wsel   = addr[2 +: WB];
        assign r_wsel = r_addr[2 +: WB];
    end else begin : g_wsel0
        assign wsel   = '0;
        assign r_wsel = '0;
    end

    assign sz       = sign_mask[2:0];
    assign align_ok = (sz == 3'b001)
                   || (sz == 3'b011 && !addr[0])
                   || (sz == 3'b111 && addr[1:0] == 2'b00);
    assign req_any  = memwrite || memread;
    assign req_ok   = req_any && align_ok;
    assign bad_req  = req_any && !align_ok;
    assign hit      = valid[idx] && (tags[idx] == tag);

    assign ack_ok    = mem_req && mem_ack;
    assign last_beat = (beat == LAST);
    assign word_addr = {addr[ADDR_W-1:2], 2'b00};
    assign line_addr = addr & ~ADDR_W'(WORDS_PER_LINE * 4 - 1);
    assign fill_word = (r_wsel == LAST) ? mem_rdata
                                        : dmem[r_idx][r_wsel];

    always_comb begin
        rep_data = write_data;
        be_base  = 4'b1111;
        unique case (sz)
            3'b001: begin
                rep_data = {4{write_data[7:0]}};
                be_base  = 4'b0001;
            end
            3'b011: begin
                rep_data = {2{write_data[15:0]}};
                be_base  = 4'b0011;
            end
            default: ;
        endcase
    end

    function automatic logic [31:0] extract(
        input logic [31:0] w,
        input logic [1:0]  off,
        input logic [3:0]  sm
    );
        logic [31:0] s;
        s = w >> {off, 3'b000};
        unique case (sm[2:0])
            3'b001:  return sm[3] ? {{24{s[7]}}, s[7:0]}
                                  : {24'b0, s[7:0]};
            3'b011:  return sm[3] ? {{16{s[15]}}, s[15:0]}
                                  : {16'b0, s[15:0]};
            default: return s;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        clk_stall = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_ok) begin
                    clk_stall = memwrite || !hit;
                    if (memwrite)  state_d = WRITE;
                    else if (!hit) state_d = REFILL;
                end
            end
            REFILL: begin
                clk_stall = 1'b1;
                if (ack_ok && last_beat) state_d = DONE;
            end
            WRITE: begin
                clk_stall = 1'b1;
                if (ack_ok) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data  <= '0;
            misaligned <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            valid      <= '0;
            r_addr     <= '0;
            r_sm       <= '0;
            r_hit      <= 1'b0;
            beat       <= '0;
        end else begin
            misaligned <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bad_req) begin
                        misaligned <= 1'b1;
                    end else if (memwrite) begin
                        r_addr    <= addr;
                        r_sm      <= sign_mask;
                        r_hit     <= hit;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= word_addr;
                        mem_wdata <= rep_data;
                        mem_be    <= be_base << addr[1:0];
                    end else if (memread && hit) begin
                        read_data <= extract(dmem[idx][wsel],
                                             addr[1:0], sign_mask);
                        if (hit_count != '1)
                            hit_count <= hit_count + CNT_W'(1);
                    end else if (memread) begin
                        if (miss_count != '1)
                            miss_count <= miss_count + CNT_W'(1);
                        r_addr   <= addr;
                        r_sm     <= sign_mask;
                        beat     <= '0;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_be   <= '0;
                        mem_addr <= line_addr;
                    end
                end
                REFILL: begin
                    if (ack_ok) begin
                        if (last_beat) begin
                            mem_req      <= 1'b0;
                            valid[r_idx] <= 1'b1;
                            read_data    <= extract(fill_word,
                                                    r_addr[1:0], r_sm);
                        end else begin
                            beat     <= beat + WI'(1);
                            mem_addr <= mem_addr + ADDR_W'(4);
                        end
                    end
                end
                WRITE: begin
                    if (ack_ok) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line storage needs no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (state_q == REFILL && ack_ok) begin
            dmem[r_idx][beat] <= mem_rdata;
            if (last_beat) tags[r_idx] <= r_tag;
        end
        if (state_q == WRITE && ack_ok && r_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b])
                    dmem[r_idx][r_wsel][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_cache_param.sv
// Directed self-checking bench for data_cache_param
// with a behavioural backing memory responder.
module tb_data_cache_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] write_data = '0;
    logic        memwrite = 1'b0;
    logic        memread = 1'b0;
    logic [3:0]  sign_mask = '0;
    logic [31:0] read_data;
    logic        clk_stall;
    logic        misaligned;
    logic [15:0] hit_count;
    logic [15:0] miss_count;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int errors = 0;
    int checks = 0;

    logic [31:0] bmem [0:1023];
    logic [31:0] beat_q [$];
    logic [3:0]  last_be;
    logic [31:0] last_wdata;
    logic [31:0] last_waddr;
    int          lat = 0;
    int          lat_cnt = 0;
    bit          spurious = 0;
    bit          req_seen = 0;

    data_cache_param dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .write_data (write_data),
        .memwrite   (memwrite),
        .memread    (memread),
        .sign_mask  (sign_mask),
        .read_data  (read_data),
        .clk_stall  (clk_stall),
        .misaligned (misaligned),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    // Backing memory: acks after lat idle cycles per beat.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req) begin
                req_seen = 1;
                if (lat_cnt >= lat) begin
                    lat_cnt = 0;
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        last_be    = mem_be;
                        last_wdata = mem_wdata;
                        last_waddr = mem_addr;
                        for (int b = 0; b < 4; b++)
                            if (mem_be[b])
                                bmem[mem_addr[11:2]][8*b +: 8] =
                                    mem_wdata[8*b +: 8];
                    end else begin
                        mem_rdata = bmem[mem_addr[11:2]];
                        beat_q.push_back(mem_addr);
                    end
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
                if (spurious) begin
                    mem_ack   = 1'b1;
                    mem_rdata = 32'hDEADBEEF;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        memwrite = 1'b0;
        memread = 1'b0;
        lat = 0;
        spurious = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        beat_q.delete();
        req_seen = 0;
    endtask

    task automatic access(
        input logic w, input logic r, input logic [31:0] a,
        input logic [31:0] d, input logic [3:0] sm,
        output int stalls
    );
        int n;
        @(negedge clk);
        #1;
        addr = a; write_data = d; sign_mask = sm;
        memwrite = w; memread = r;
        #1;
        stalls = 0;
        n = 0;
        while (clk_stall && n < 500) begin
            stalls++;
            n++;
            @(negedge clk);
            #2;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL access_timeout: addr %h still stalled after %0d cycles, want release", a, n);
        end
        @(posedge clk);
        #1;
        memwrite = 1'b0;
        memread = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (read_data !== 32'h0 || misaligned !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: read_data %h misaligned %b, want 0/0", read_data, misaligned);
        end
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_be !== 4'h0) begin
            errors++;
            $display("FAIL reset_bus_ctl: req %b we %b be %h, want 0/0/0", mem_req, mem_we, mem_be);
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus_data: addr %h wdata %h, want 0/0", mem_addr, mem_wdata);
        end
        checks++;
        if (hit_count !== 16'h0 || miss_count !== 16'h0 || clk_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt: hit %0d miss %0d stall %b, want 0/0/0", hit_count, miss_count, clk_stall);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_byte();
        int s;
        do_reset();
        access(1, 0, 32'h400, 32'hAAA, 4'b0001, s);
        checks++;
        if (last_be !== 4'b0001 || last_wdata !== 32'hAAAAAAAA) begin
            errors++;
            $display("FAIL byte_store: be %b wdata %h, want 0001/aaaaaaaa", last_be, last_wdata);
        end
        checks++;
        if (s == 0) begin
            errors++;
            $display("FAIL byte_store_stall: stalls %0d, want >0", s);
        end
        access(0, 1, 32'h400, 32'h0, 4'b1001, s);
        checks++;
        if (read_data !== 32'hFFFFFFAA || miss_count !== 16'd1) begin
            errors++;
            $display("FAIL byte_signed: data %h miss %0d, want ffffffaa/1", read_data, miss_count);
        end
        access(0, 1, 32'h400, 32'h0, 4'b0001, s);
        checks++;
        if (read_data !== 32'h000000AA || hit_count !== 16'd1 || s != 0) begin
            errors++;
            $display("FAIL byte_unsigned: data %h hit %0d stalls %0d, want 000000aa/1/0", read_data, hit_count, s);
        end
    endtask

    task automatic test_half();
        int s;
        do_reset();
        access(1, 0, 32'h100, 32'h2AAAA, 4'b0011, s);
        checks++;
        if (last_be !== 4'b0011 || last_wdata !== 32'hAAAAAAAA) begin
            errors++;
            $display("FAIL half_store: be %b wdata %h, want 0011/aaaaaaaa", last_be, last_wdata);
        end
        access(0, 1, 32'h100, 32'h0, 4'b1011, s);
        checks++;
        if (read_data !== 32'hFFFFAAAA) begin
            errors++;
            $display("FAIL half_signed: got %h want ffffaaaa", read_data);
        end
        access(0, 1, 32'h100, 32'h0, 4'b0011, s);
        checks++;
        if (read_data !== 32'h0000AAAA || s != 0) begin
            errors++;
            $display("FAIL half_unsigned: data %h stalls %0d, want 0000aaaa/0", read_data, s);
        end
        access(1, 0, 32'h102, 32'h1234, 4'b0011, s);
        checks++;
        if (last_be !== 4'b1100 || last_waddr !== 32'h100) begin
            errors++;
            $display("FAIL half_upper_store: be %b addr %h, want 1100/100", last_be, last_waddr);
        end
        access(0, 1, 32'h100, 32'h0, 4'b0111, s);
        checks++;
        if (read_data !== 32'h1234AAAA || hit_count !== 16'd2) begin
            errors++;
            $display("FAIL half_write_hit: data %h hit %0d, want 1234aaaa/2", read_data, hit_count);
        end
    endtask

    task automatic test_word();
        int s;
        do_reset();
        access(1, 0, 32'h40, 32'hAAAAAAAA, 4'b0111, s);
        checks++;
        if (last_be !== 4'b1111) begin
            errors++;
            $display("FAIL word_store: be %b want 1111", last_be);
        end
        beat_q.delete();
        access(0, 1, 32'h40, 32'h0, 4'b0111, s);
        checks++;
        if (read_data !== 32'hAAAAAAAA || miss_count !== 16'd1) begin
            errors++;
            $display("FAIL word_miss: data %h miss %0d, want aaaaaaaa/1", read_data, miss_count);
        end
        checks++;
        if (beat_q.size() != 4 || beat_q[0] !== 32'h40 || beat_q[1] !== 32'h44
            || beat_q[2] !== 32'h48 || beat_q[3] !== 32'h4C) begin
            errors++;
            $display("FAIL word_beats: %0d beats first %h, want 4 beats 40..4c", beat_q.size(), beat_q.size() ? beat_q[0] : 32'hx);
        end
        access(0, 1, 32'h40, 32'h0, 4'b0111, s);
        checks++;
        if (hit_count !== 16'd1 || s != 0 || read_data !== 32'hAAAAAAAA) begin
            errors++;
            $display("FAIL word_hit: hit %0d stalls %0d data %h, want 1/0/aaaaaaaa", hit_count, s, read_data);
        end
        access(1, 0, 32'h41, 32'h55, 4'b0001, s);
        checks++;
        if (last_be !== 4'b0010 || last_waddr !== 32'h40) begin
            errors++;
            $display("FAIL byte_lane1: be %b addr %h, want 0010/40", last_be, last_waddr);
        end
        access(0, 1, 32'h40, 32'h0, 4'b0111, s);
        checks++;
        if (read_data !== 32'hAAAA55AA || hit_count !== 16'd2) begin
            errors++;
            $display("FAIL byte_write_hit: data %h hit %0d, want aaaa55aa/2", read_data, hit_count);
        end
    endtask

    task automatic test_conflict();
        int s;
        logic [31:0] a, exp;
        do_reset();
        lat = 2;
        bmem[32'h80 >> 2]  = 32'h11112222;
        bmem[32'h180 >> 2] = 32'h33334444;
        for (int i = 0; i < 4; i++) begin
            a   = (i % 2 == 0) ? 32'h80 : 32'h180;
            exp = (i % 2 == 0) ? 32'h11112222 : 32'h33334444;
            beat_q.delete();
            access(0, 1, a, 32'h0, 4'b0111, s);
            checks++;
            if (read_data !== exp || miss_count !== 16'(i + 1)
                || hit_count !== 16'd0 || beat_q.size() != 4) begin
                errors++;
                $display("FAIL conflict_%0d: data %h miss %0d hit %0d beats %0d, want %h/%0d/0/4", i, read_data, miss_count, hit_count, beat_q.size(), exp, i + 1);
            end
        end
    endtask

    task automatic test_misaligned();
        int s;
        do_reset();
        access(0, 1, 32'h101, 32'h0, 4'b0011, s);
        checks++;
        if (misaligned !== 1'b1 || s != 0) begin
            errors++;
            $display("FAIL misalign_pulse: misaligned %b stalls %0d, want 1/0", misaligned, s);
        end
        @(posedge clk);
        #1;
        checks++;
        if (misaligned !== 1'b0) begin
            errors++;
            $display("FAIL misalign_width: misaligned %b want 0", misaligned);
        end
        access(0, 1, 32'h42, 32'h0, 4'b0111, s);
        checks++;
        if (misaligned !== 1'b1) begin
            errors++;
            $display("FAIL misalign_word: misaligned %b want 1", misaligned);
        end
        access(0, 1, 32'h0, 32'h0, 4'b0010, s);
        checks++;
        if (misaligned !== 1'b1) begin
            errors++;
            $display("FAIL misalign_size: misaligned %b want 1", misaligned);
        end
        access(1, 0, 32'h103, 32'hFFFF, 4'b0011, s);
        checks++;
        if (misaligned !== 1'b1) begin
            errors++;
            $display("FAIL misalign_store: misaligned %b want 1", misaligned);
        end
        spurious = 1;
        repeat (3) @(negedge clk);
        spurious = 0;
        #2;
        checks++;
        if (req_seen || hit_count !== 16'd0 || miss_count !== 16'd0
            || read_data !== 32'h0 || clk_stall !== 1'b0) begin
            errors++;
            $display("FAIL misalign_quiet: req_seen %0d hit %0d miss %0d data %h stall %b, want 0/0/0/0/0", req_seen, hit_count, miss_count, read_data, clk_stall);
        end
    endtask

    task automatic test_reset_refill();
        int s, n;
        do_reset();
        lat = 3;
        bmem[32'h300 >> 2] = 32'hCAFEF00D;
        @(negedge clk);
        #1;
        addr = 32'h300; sign_mask = 4'b0111; memread = 1'b1;
        n = 0;
        while (beat_q.size() < 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL refill_start: no beat after %0d cycles, want 1 beat", n);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || miss_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_refill: req %b miss %0d, want 0/0", mem_req, miss_count);
        end
        memread = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        lat = 0;
        beat_q.delete();
        access(0, 1, 32'h300, 32'h0, 4'b0111, s);
        checks++;
        if (miss_count !== 16'd1 || s == 0 || read_data !== 32'hCAFEF00D
            || beat_q.size() != 4) begin
            errors++;
            $display("FAIL refill_after_reset: miss %0d stalls %0d data %h beats %0d, want 1/>0/cafef00d/4", miss_count, s, read_data, beat_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) bmem[i] = '0;
        test_reset();
        test_byte();
        test_half();
        test_word();
        test_conflict();
        test_misaligned();
        test_reset_refill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
